// File: rtl/vga_fb_pkg.sv
// Shared constants and owner-state encoding for the VGA framebuffer RAM arbiter.
package vga_fb_pkg;

    localparam int unsigned IMG_W    = 200;
    localparam int unsigned IMG_H    = 200;
    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned IMG_SIZE = IMG_W * IMG_H;
    localparam int unsigned STARVE_W = 8;

    // What the RAM port does in the next cycle.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } owner_e;

endpackage

// File: rtl/fb_disp_addr_gen.sv
// Display read address counter: wraps after the last pixel, clear rewinds to 0.
module fb_disp_addr_gen #(
    parameter int unsigned SIZE   = vga_fb_pkg::IMG_SIZE,
    parameter int unsigned ADDR_W = vga_fb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] rd_addr_c
);
    import vga_fb_pkg::*;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SIZE - 1);

    logic [ADDR_W-1:0] addr;

    // A clear in the same cycle as a read makes this read hit pixel 0.
    assign rd_addr_c = clr ? '0 : addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (en) begin
            addr <= (rd_addr_c == LAST) ? '0 : rd_addr_c + ADDR_W'(1);
        end else if (clr) begin
            addr <= '0;
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares the single-port image RAM between the display read stream and a
// loader write port; display has priority, a starvation limit forces writes.
module vga_fb_arbiter #(
    parameter int unsigned IMG_W      = vga_fb_pkg::IMG_W,
    parameter int unsigned IMG_H      = vga_fb_pkg::IMG_H,
    parameter int unsigned ADDR_W     = vga_fb_pkg::ADDR_W,
    parameter int unsigned DATA_W     = vga_fb_pkg::DATA_W,
    parameter int unsigned STARVE_LIM = 16
) (
    input  logic              vga_clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              disp_req,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_vld,
    output logic              disp_dup,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    import vga_fb_pkg::*;

    localparam int unsigned     SIZE   = IMG_W * IMG_H;
    localparam logic [ADDR_W:0] SIZE_X = (ADDR_W + 1)'(SIZE);
    localparam logic [7:0]      LIM    = 8'(STARVE_LIM);
    localparam bit              LIM_ON = (STARVE_LIM != 0);

    owner_e            state;
    logic [7:0]        starve_cnt;
    logic              dup1;
    logic              p2_vld;
    logic              p2_dup;
    logic [ADDR_W-1:0] rd_addr;

    logic force_wr;
    logic wr_ready_c;
    logic xfer;
    logic rd_en;
    logic dup_en;
    logic in_range;

    fb_disp_addr_gen #(
        .SIZE   (SIZE),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (vga_clk),
        .rst_n     (rst_n),
        .clr       (frame_start),
        .en        (rd_en),
        .rd_addr_c (rd_addr)
    );

    // Per-cycle arbitration decision.
    always_comb begin
        force_wr   = 1'b0;
        wr_ready_c = 1'b0;
        xfer       = 1'b0;
        rd_en      = 1'b0;
        dup_en     = 1'b0;
        in_range   = 1'b0;
        force_wr   = LIM_ON && (starve_cnt == LIM) && wr_valid;
        wr_ready_c = rst_n && (!disp_req || force_wr);
        xfer       = wr_valid && wr_ready_c;
        rd_en      = disp_req && !force_wr;
        dup_en     = disp_req && force_wr;
        in_range   = {1'b0, wr_addr} < SIZE_X;
    end

    // The grant is a same-cycle answer to the requesters, so it stays combinational.
    assign wr_ready = wr_ready_c;

    // Owner state, RAM command, read-return pipe and starvation counter.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_wdata  <= '0;
            wr_err     <= 1'b0;
            starve_cnt <= '0;
            dup1       <= 1'b0;
            p2_vld     <= 1'b0;
            p2_dup     <= 1'b0;
            disp_vld   <= 1'b0;
            disp_dup   <= 1'b0;
            disp_data  <= '0;
        end else begin
            ram_we <= 1'b0;
            wr_err <= 1'b0;
            if (xfer) begin
                state     <= S_WR;
                ram_addr  <= wr_addr;
                ram_wdata <= wr_data;
                ram_we    <= in_range;
                wr_err    <= !in_range;
            end else if (rd_en) begin
                state    <= S_RD;
                ram_addr <= rd_addr;
            end else begin
                state <= S_IDLE;
            end

            // A stolen display slot still returns one (repeated) pixel in order.
            dup1     <= dup_en;
            p2_vld   <= (state == S_RD) || dup1;
            p2_dup   <= dup1;
            disp_vld <= p2_vld;
            disp_dup <= p2_vld && p2_dup;
            if (p2_vld && !p2_dup) begin
                disp_data <= ram_rdata;
            end

            if (!wr_valid || xfer) begin
                starve_cnt <= '0;
            end else if (starve_cnt != 8'hFF) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a cycle-indexed behavioural model of the RAM sharing rules.
module tb_vga_fb_arbiter;

    localparam int IMG_SIZE = 40000;
    localparam int LIM      = 16;

    logic        vga_clk     = 1'b0;
    logic        rst_n       = 1'b0;
    logic        frame_start = 1'b0;
    logic        disp_req    = 1'b0;
    logic        wr_valid    = 1'b0;
    logic [15:0] wr_addr     = '0;
    logic [7:0]  wr_data     = '0;
    logic [7:0]  disp_data;
    logic        disp_vld;
    logic        disp_dup;
    logic        wr_ready;
    logic        wr_err;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = '0;

    logic [7:0] mem [0:65535];
    logic [7:0] img [0:65535];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Model state and expectation ring indexed by cycle number.
    int   m_daddr, m_starve, m_last, m_raddr, m_wdata;
    bit   e_rdy;
    logic        e_vld [8];
    logic        e_dup [8];
    logic        e_we  [8];
    logic        e_err [8];
    logic [7:0]  e_data[8];
    logic [7:0]  e_wd  [8];
    logic [15:0] e_addr[8];

    logic [8:0] pix_q[$];
    int         pix_cyc[$];
    int         acc_q[$];

    vga_fb_arbiter #(.STARVE_LIM(LIM)) dut (
        .vga_clk     (vga_clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .disp_req    (disp_req),
        .disp_data   (disp_data),
        .disp_vld    (disp_vld),
        .disp_dup    (disp_dup),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_err      (wr_err),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    always #5 vga_clk = ~vga_clk;

    // Synchronous read-first RAM macro.
    always @(posedge vga_clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endfunction

    task automatic model_reset();
        m_daddr = 0; m_starve = 0; m_last = 0; m_raddr = 0; m_wdata = 0;
        for (int k = 0; k < 8; k++) begin
            e_vld[k] = 0; e_dup[k] = 0; e_we[k] = 0; e_err[k] = 0;
            e_data[k] = '0; e_wd[k] = '0; e_addr[k] = '0;
        end
    endtask

    // Apply the sharing rules to this cycle's inputs; fills t+1 RAM and t+3 display slots.
    task automatic model_eval();
        bit frc, xfer;
        int base, n, m;
        frc   = (m_starve == LIM) && wr_valid;
        e_rdy = !disp_req || frc;
        xfer  = wr_valid && e_rdy;
        base  = frame_start ? 0 : m_daddr;
        n = (cyc + 1) % 8;
        m = (cyc + 3) % 8;
        e_we[n]  = 0;
        e_err[n] = 0;
        if (xfer) begin
            m_raddr = int'(wr_addr);
            m_wdata = int'(wr_data);
            if (int'(wr_addr) < IMG_SIZE) begin
                e_we[n] = 1;
                img[wr_addr] = wr_data;
            end else begin
                e_err[n] = 1;
            end
            m_daddr = base;
        end else if (disp_req) begin
            m_raddr = base;
            m_daddr = (base + 1) % IMG_SIZE;
        end else begin
            m_daddr = base;
        end
        e_addr[n] = 16'(m_raddr);
        e_wd[n]   = 8'(m_wdata);
        e_vld[m]  = disp_req;
        e_dup[m]  = disp_req && frc;
        if (disp_req && !frc) m_last = int'(img[base]);
        e_data[m] = 8'(m_last);
        m_starve  = (!wr_valid || xfer) ? 0 : ((m_starve < 255) ? m_starve + 1 : 255);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge vga_clk) begin : cmp
        int k;
        if (chk_en) begin
            k = cyc % 8;
            chk("disp_vld",  32'(disp_vld),  32'(e_vld[k]));
            chk("disp_dup",  32'(disp_dup),  32'(e_dup[k]));
            chk("disp_data", 32'(disp_data), 32'(e_data[k]));
            chk("ram_we",    32'(ram_we),    32'(e_we[k]));
            chk("wr_err",    32'(wr_err),    32'(e_err[k]));
            chk("ram_addr",  32'(ram_addr),  32'(e_addr[k]));
            chk("ram_wdata", 32'(ram_wdata), 32'(e_wd[k]));
            chk("wr_ready",  32'(wr_ready),  32'(e_rdy));
            if (disp_vld) begin
                pix_q.push_back({disp_dup, disp_data});
                pix_cyc.push_back(cyc);
            end
            if (wr_valid && wr_ready) acc_q.push_back(cyc);
        end
    end

    task automatic drive(input bit fs, input bit dr, input bit wv, input logic [15:0] wa, input logic [7:0] wd);
        frame_start = fs; disp_req = dr; wr_valid = wv; wr_addr = wa; wr_data = wd;
        model_eval();
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
        cyc++;
    endtask

    task automatic step(input bit fs, input bit dr, input bit wv, input logic [15:0] wa, input logic [7:0] wd);
        drive(fs, dr, wv, wa, wd);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'd0, 8'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vld"},   32'(disp_vld),  32'd0);
        chk({tag, "_dup"},   32'(disp_dup),  32'd0);
        chk({tag, "_data"},  32'(disp_data), 32'd0);
        chk({tag, "_we"},    32'(ram_we),    32'd0);
        chk({tag, "_addr"},  32'(ram_addr),  32'd0);
        chk({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
        chk({tag, "_err"},   32'(wr_err),    32'd0);
        chk({tag, "_rdy"},   32'(wr_ready),  32'd0);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int s;
        bit pend, dr, fs;
        int dens;
        logic [15:0] wa;
        logic [7:0]  wd;

        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'(i);
            img[i] = 8'(i);
        end
        model_reset();

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(posedge vga_clk);
        #1;
        chk_all_zero("reset");
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Streamed reads from frame start: pixels 0..4 at t+3
        idle(2);
        pix_q.delete(); pix_cyc.delete();
        s = cyc;
        step(1, 1, 0, 16'd0, 8'd0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 16'd0, 8'd0);
        idle(5);
        chk("t1_count", 32'(pix_q.size()), 32'd5);
        if (pix_q.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("t1_pix", 32'(pix_q[i]), 32'(i));
            chk("t1_latency", 32'(pix_cyc[0] - s), 32'd3);
        end

        // Idle-bus write
        drive(0, 0, 1, 16'd100, 8'hE0);
        #1;
        chk("t2_ready", 32'(wr_ready), 32'd1);
        tick();
        chk("t2_we",    32'(ram_we),    32'd1);
        chk("t2_addr",  32'(ram_addr),  32'd100);
        chk("t2_wdata", 32'(ram_wdata), 32'h0E0);
        idle(2);

        // Starvation forcing under continuous display traffic
        pix_q.delete(); pix_cyc.delete(); acc_q.delete();
        s = cyc;
        step(1, 1, 1, 16'd39000, 8'hAA);
        for (int i = 0; i < 39; i++) step(0, 1, 1, 16'd39000, 8'hAA);
        idle(6);
        chk("t3_grants", 32'(acc_q.size()), 32'd2);
        if (acc_q.size() == 2) begin
            chk("t3_grant0", 32'(acc_q[0] - s), 32'd16);
            chk("t3_grant1", 32'(acc_q[1] - s), 32'd33);
        end
        chk("t3_count", 32'(pix_q.size()), 32'd40);
        if (pix_q.size() == 40) begin
            chk("t3_pix15",  32'(pix_q[15]), 32'd15);
            chk("t3_dup16",  32'(pix_q[16]), 32'h10F);
            chk("t3_pix17",  32'(pix_q[17]), 32'd16);
            chk("t3_dup33",  32'(pix_q[33]), 32'h11F);
            chk("t3_pix34",  32'(pix_q[34]), 32'd32);
            chk("t3_pix39",  32'(pix_q[39]), 32'd37);
        end

        // Out-of-range write
        step(0, 0, 1, 16'd40000, 8'h55);
        chk("t4_we",   32'(ram_we),   32'd0);
        chk("t4_err",  32'(wr_err),   32'd1);
        chk("t4_addr", 32'(ram_addr), 32'd40000);
        idle(1);
        chk("t4_err_end", 32'(wr_err), 32'd0);

        // Full-frame stream and wrap to 0
        pix_q.delete(); pix_cyc.delete();
        step(1, 1, 0, 16'd0, 8'd0);
        for (int i = 0; i < 39999; i++) step(0, 1, 0, 16'd0, 8'd0);
        chk("t5_last_addr", 32'(ram_addr), 32'd39999);
        step(0, 1, 0, 16'd0, 8'd0);
        chk("t5_wrap_addr", 32'(ram_addr), 32'd0);
        idle(5);
        chk("t5_count", 32'(pix_q.size()), 32'd40001);
        if (pix_q.size() == 40001) begin
            chk("t5_pix_last", 32'(pix_q[39999]), 32'h03F);
            chk("t5_pix_wrap", 32'(pix_q[40000]), 32'd0);
        end

        // frame_start mid-stream rewinds to 0
        step(1, 1, 0, 16'd0, 8'd0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 16'd0, 8'd0);
        chk("t5_mid_addr", 32'(ram_addr), 32'd10);
        step(1, 1, 0, 16'd0, 8'd0);
        chk("t5_rewind", 32'(ram_addr), 32'd0);
        step(0, 1, 0, 16'd0, 8'd0);
        chk("t5_after_rewind", 32'(ram_addr), 32'd1);
        idle(5);

        // Async reset with two reads in flight
        step(0, 1, 0, 16'd0, 8'd0);
        step(0, 1, 0, 16'd0, 8'd0);
        #2;
        rst_n = 1'b0;
        chk_en = 1'b0;
        frame_start = 0; disp_req = 0; wr_valid = 0;
        #1;
        chk_all_zero("t6_reset");
        model_reset();
        repeat (3) tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        pix_q.delete();
        idle(8);
        chk("t6_no_vld", 32'(pix_q.size()), 32'd0);

        // Randomized traffic with bursty display density and held write requests
        pend = 0; wa = '0; wd = '0; dens = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) dens = $urandom_range(0, 3);
            case (dens)
                0:       dr = ($urandom_range(0, 99) < 30);
                1:       dr = ($urandom_range(0, 99) < 70);
                2:       dr = ($urandom_range(0, 99) < 95);
                default: dr = 1'b1;
            endcase
            fs = ($urandom_range(0, 99) < 2);
            if (!pend && ($urandom_range(0, 99) < 60)) begin
                pend = 1;
                wa = ($urandom_range(0, 9) == 0) ? 16'(40000 + $urandom_range(0, 25535))
                                                  : 16'($urandom_range(0, 39999));
                wd = 8'($urandom);
            end
            drive(fs, dr, pend, wa, wd);
            if (pend && e_rdy) pend = 0;
            tick();
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Arbiter and sequencer for the single-port 200x200x8 image RAM that feeds the VGA pixel path. It shares the RAM between the display read stream (`disp_req` from the timing generator while the moving window is active) and a write requester (image loader) using a valid/ready handshake. Display reads have priority, and a starvation limit guarantees the writer forward progress. It sits between the VGA timing/area logic, the loader and the RAM macro, all on `vga_clk`.

## Interface
- `IMG_W`, 200, image width in pixels
- `IMG_H`, 200, image height in pixels
- `ADDR_W`, 16, RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- `DATA_W`, 8, pixel width, {r[2:0],g[2:0],b[1:0]}
- `STARVE_LIM`, 16, consecutive blocked cycles before a write is forced; 0 disables forcing
- `vga_clk`  in  1  sole clock; all logic on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `frame_start`  in  1  one-cycle pulse; rewinds display address to 0
- `disp_req`  in  1  display needs next pixel; issued 3 cycles before use
- `disp_data`  out  DATA_W  pixel returned to display
- `disp_vld`  out  1  `disp_data` valid this cycle
- `disp_dup`  out  1  with `disp_vld`: pixel is a repeat (slot given to a write)
- `wr_valid`  in  1  write request
- `wr_ready`  out  1  write slot granted this cycle
- `wr_addr`  in  ADDR_W  write address
- `wr_data`  in  DATA_W  write pixel
- `wr_err`  out  1  one-cycle pulse: accepted write had address out of range
- `ram_addr`  out  ADDR_W  RAM address (registered)
- `ram_we`  out  1  RAM write enable (registered)
- `ram_wdata`  out  DATA_W  RAM write data (registered)
- `ram_rdata`  in  DATA_W  RAM read data, valid the cycle after `ram_addr`

## Operation
- Owner FSM, states S_IDLE, S_RD, S_WR = what the RAM port does next cycle; re-evaluated every cycle, no multi-cycle occupancy.
- Per cycle: force = (STARVE_LIM != 0) && (starve_cnt == STARVE_LIM) && wr_valid.
- `wr_ready` = !disp_req || force (never depends on `wr_valid` alone being low).
- Transfer = wr_valid && wr_ready -> S_WR: ram_addr<=wr_addr, ram_wdata<=wr_data, ram_we<=1 if wr_addr < IMG_W*IMG_H, else ram_we<=0 and `wr_err` pulses next cycle.
- disp_req && !force -> S_RD: ram_addr<=disp_addr, ram_we<=0, disp_addr advances.
- disp_req && force -> S_WR as above; disp_addr does not advance; a dup token enters the read pipe.
- Neither -> S_IDLE, ram_we<=0, ram_addr holds.
- disp_addr: 0..IMG_W*IMG_H-1, wraps to 0 after last pixel. frame_start clears it; with simultaneous disp_req, address 0 is read and disp_addr becomes 1.
- starve_cnt (8 bit, saturating): +1 when wr_valid && disp_req && !force; cleared on transfer or when wr_valid low.
- Read return: 2-stage valid/dup shift; stage 2 captures ram_rdata into disp_data (S_RD) or holds disp_data (dup).

## Timing
- Reset: all outputs 0, disp_addr 0, starve_cnt 0, FSM S_IDLE, pipe empty.
- Display latency: disp_req at cycle t -> ram_addr at t+1 -> disp_vld/disp_data at t+3; every disp_req yields exactly one disp_vld, in order.
- Write latency: transfer at t -> ram_we high at t+1; wr_err at t+1.
- Forced write: exactly one cycle, then starve_cnt=0; next force at earliest STARVE_LIM+1 cycles later.
- Async reset mid-operation discards in-flight reads; no disp_vld after release until a new disp_req.

## Structure
- Shared package `vga_fb_pkg`: IMG_W, IMG_H, ADDR_W, DATA_W, derived IMG_SIZE, owner state encoding (S_IDLE/S_RD/S_WR).
- One sub-module `fb_disp_addr_gen`: wrapping display address counter with clear and enable.

## Test plan
- Reset, then disp_req for 5 cycles from frame_start, RAM preloaded addr=data -> disp_vld at t+3.., data 0,1,2,3,4, disp_dup=0.
- wr_valid with disp_req low, wr_addr=100, wr_data=8'hE0 -> wr_ready=1, ram_we=1/ram_addr=100/ram_wdata=E0 next cycle.
- disp_req and wr_valid held continuously, STARVE_LIM=16 -> wr_ready high on 17th cycle only, one disp_dup repeating previous pixel, disp_addr skips none.
- wr_addr=40000 accepted -> ram_we=0, wr_err pulse one cycle after transfer.
- Stream to address 39999 then one more disp_req -> address wraps to 0; frame_start mid-stream with disp_req -> next read addr 0.
- Assert rst_n low with two reads in flight -> all outputs 0 immediately, no disp_vld after release.
